// File: rtl/keccak_pkg.sv
// Shared Keccak arbiter definitions: FSM encoding, mode codes, core rate constants.
package keccak_pkg;

    localparam int unsigned N_REQ_MAX = 8;
    localparam int unsigned RATE_1088 = 1088;
    localparam int unsigned RATE_1344 = 1344;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        MODE_SHA3_256 = 2'b00,
        MODE_SHA3_512 = 2'b01,
        MODE_SHAKE256 = 2'b10,
        MODE_SHAKE128 = 2'b11
    } keccak_mode_e;

endpackage

// File: rtl/keccak_arbiter_if.sv
// Requester-side and core-side signal bundle of the Keccak arbiter.
interface keccak_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = 64
);
    logic [N_REQ-1:0]    req;
    logic [2*N_REQ-1:0]  req_mode;
    logic [32*N_REQ-1:0] req_outlen;
    logic [N_REQ-1:0]    grant;
    logic [N_REQ-1:0]    done;
    logic [DW*N_REQ-1:0] in_data;
    logic [N_REQ-1:0]    in_valid;
    logic [N_REQ-1:0]    in_last;
    logic [N_REQ-1:0]    in_ready;
    logic [DW-1:0]       out_data;
    logic [N_REQ-1:0]    out_valid;
    logic                core_start;
    logic [1:0]          core_mode;
    logic [31:0]         core_outlen;
    logic [DW-1:0]       core_in_data;
    logic                core_in_valid;
    logic                core_in_last;
    logic                core_in_ready;
    logic [DW-1:0]       core_out_data;
    logic                core_out_valid;
    logic                core_done;

    // Arbiter side
    modport slave (
        input  req, req_mode, req_outlen, in_data, in_valid, in_last,
               core_in_ready, core_out_data, core_out_valid, core_done,
        output grant, done, in_ready, out_data, out_valid,
               core_start, core_mode, core_outlen,
               core_in_data, core_in_valid, core_in_last
    );

    // Requesters and core side
    modport master (
        output req, req_mode, req_outlen, in_data, in_valid, in_last,
               core_in_ready, core_out_data, core_out_valid, core_done,
        input  grant, done, in_ready, out_data, out_valid,
               core_start, core_mode, core_outlen,
               core_in_data, core_in_valid, core_in_last
    );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin winner select starting at ptr.
// KECCAK_ARB_PRIO0_EN: requester 0 always wins; rotation covers 1..N_REQ-1 only.
module rr_picker #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [IW-1:0]    win_idx,
    output logic             any
);
    logic [N_REQ-1:0] rot_req;
    int unsigned      k;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        any     = 1'b0;
        k       = 0;
        rot_req = req;
`ifdef KECCAK_ARB_PRIO0_EN
        rot_req[0] = 1'b0;
        if (req[0]) begin
            win_oh[0] = 1'b1;
            any       = 1'b1;
        end
`endif
        for (int unsigned i = 0; i < N_REQ; i++) begin
            k = (32'(ptr) + i) % N_REQ;
            if (!any && rot_req[k]) begin
                win_oh[k] = 1'b1;
                win_idx   = IW'(k);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/keccak_arbiter.sv
// Round-robin arbiter sharing one Keccak core among N_REQ requesters with job locking.
// KECCAK_ARB_PRIO0_EN: requester 0 takes precedence whenever it requests in IDLE.
module keccak_arbiter
    import keccak_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = 64
) (
    input logic             clk,
    input logic             rst,
    keccak_arbiter_if.slave bus
);
    localparam int unsigned IW = $clog2(N_REQ);

    arb_state_e       state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    ptr_nxt;
    logic [N_REQ-1:0] owner_oh;
    logic [N_REQ-1:0] grant_q;
    logic             core_start_q;
    logic [1:0]       core_mode_q;
    logic [31:0]      core_outlen_q;
    logic [N_REQ-1:0] win_oh;
    logic [IW-1:0]    win_idx;
    logic             win_any;
    logic             busy;

    rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req     (bus.req),
        .ptr     (ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (win_any)
    );

    assign busy     = (state == ST_BUSY);
    assign owner_oh = N_REQ'(1) << owner;

    // Pointer moves past the finished owner; with priority mode it never rotates onto 0
    always_comb begin
        ptr_nxt = (32'(owner) == N_REQ - 1) ? '0 : owner + IW'(1);
`ifdef KECCAK_ARB_PRIO0_EN
        if (ptr_nxt == '0) ptr_nxt = IW'(1);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            owner         <= '0;
            grant_q       <= '0;
            core_start_q  <= 1'b0;
            core_mode_q   <= 2'b00;
            core_outlen_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        owner         <= win_idx;
                        grant_q       <= win_oh;
                        core_start_q  <= 1'b1;
                        core_mode_q   <= bus.req_mode[32'(win_idx)*2 +: 2];
                        core_outlen_q <= bus.req_outlen[32'(win_idx)*32 +: 32];
                        state         <= ST_START;
                    end
                end
                ST_START: begin
                    core_start_q <= 1'b0;
                    state        <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (bus.core_done) begin
                        grant_q <= '0;
                        ptr     <= ptr_nxt;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.core_start  = core_start_q;
    assign bus.core_mode   = core_mode_q;
    assign bus.core_outlen = core_outlen_q;
    assign bus.out_data    = bus.core_out_data;

    // Owner-only routing of streams; done is suppressed while reset aborts the job
    always_comb begin
        bus.done          = '0;
        bus.in_ready      = '0;
        bus.out_valid     = '0;
        bus.core_in_data  = '0;
        bus.core_in_valid = 1'b0;
        bus.core_in_last  = 1'b0;
        if (busy) begin
            bus.core_in_data  = bus.in_data[32'(owner)*DW +: DW];
            bus.core_in_valid = bus.in_valid[owner];
            bus.core_in_last  = bus.in_last[owner];
            if (bus.core_in_ready)       bus.in_ready  = owner_oh;
            if (bus.core_out_valid)      bus.out_valid = owner_oh;
            if (bus.core_done && !rst)   bus.done      = owner_oh;
        end
    end

endmodule
